// File: rtl/sc_s2b_pkg.sv
// Shared types and helpers for the windowed stochastic-to-binary converter.
package sc_s2b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ACC  = 2'd2
  } state_t;

  localparam int MAX_LOG_LEN = 16;
  localparam int MAX_DW      = MAX_LOG_LEN + 2;

  // 2*ones - 2^log_len at the widest legal size; callers truncate to their DW.
  function automatic logic [MAX_DW-1:0] bipolar_val(input logic [MAX_LOG_LEN:0] ones,
                                                    input int log_len);
    logic [MAX_DW-1:0] twice;
    logic [MAX_DW-1:0] bias;
    twice = {ones, 1'b0};
    bias  = MAX_DW'(1) << log_len;
    return twice - bias;
  endfunction

endpackage

// File: rtl/sc_en_cnt.sv
// Enable-gated up-counter with synchronous clear (clear wins) and async reset.
module sc_en_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/sc_s2b_window.sv
// Counts ones over a 2^LOG_LEN window of accepted bits after a warm-up discard,
// and reports the result in unipolar or bipolar form with a one-cycle valid.
module sc_s2b_window
  import sc_s2b_pkg::*;
#(
  parameter  int LOG_LEN = 8,
  parameter  int WARMUP  = 4,
  parameter  int BIPOLAR = 1,
  localparam int DW      = LOG_LEN + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in,
  input  logic          in_vld,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int            CW        = LOG_LEN + 1;
  localparam logic [7:0]    WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0] WIN_LAST  = {1'b0, {LOG_LEN{1'b1}}};

  state_t        state_reg, state_next;
  logic          busy_reg, dout_vld_reg;
  logic [DW-1:0] dout_reg, dout_next;
  logic [7:0]    warm_cnt;
  logic [CW-1:0] win_cnt, ones_cnt, ones_inc;
  logic          start_acc, warm_en, acc_en, last;

  assign start_acc = (state_reg == IDLE) && start;
  assign warm_en   = (state_reg == WARM) && in_vld;
  assign acc_en    = (state_reg == ACC) && in_vld;
  // Window counter MSB would set on this edge: the current bit closes the window.
  assign last      = acc_en && (win_cnt == WIN_LAST);
  assign ones_inc  = ones_cnt + CW'(in);

  sc_en_cnt #(.W(8)) u_warm_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(warm_en), .cnt(warm_cnt)
  );

  sc_en_cnt #(.W(CW)) u_win_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(acc_en), .cnt(win_cnt)
  );

  sc_en_cnt #(.W(CW)) u_ones_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(acc_en && in), .cnt(ones_cnt)
  );

  always_comb begin
    state_next = state_reg;
    dout_next  = DW'(ones_inc);
    if (BIPOLAR != 0) dout_next = DW'(bipolar_val(17'(ones_inc), LOG_LEN));
    case (state_reg)
      IDLE: if (start) state_next = (WARMUP > 0) ? WARM : ACC;
      WARM: if (warm_en && (warm_cnt == WARM_LAST)) state_next = ACC;
      ACC:  if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= (state_next != IDLE);
      dout_vld_reg <= last;
      if (last) dout_reg <= dout_next;
    end
  end

  assign busy     = busy_reg;
  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;

endmodule

// File: tb/tb_sc_s2b_window.sv
// Directed bench: three converter instances (unipolar, bipolar, no warm-up), LOG_LEN=4.
module tb_sc_s2b_window;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_vld = 1'b0;
  logic       start_a [3];
  logic       busy_a  [3];
  logic       vld_a   [3];
  logic [5:0] dout_a  [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sc_s2b_window #(.LOG_LEN(4), .WARMUP(2), .BIPOLAR(0)) u_uni (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .in(in_bit), .in_vld(in_vld),
    .busy(busy_a[0]), .dout(dout_a[0]), .dout_vld(vld_a[0])
  );

  sc_s2b_window #(.LOG_LEN(4), .WARMUP(2), .BIPOLAR(1)) u_bip (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .in(in_bit), .in_vld(in_vld),
    .busy(busy_a[1]), .dout(dout_a[1]), .dout_vld(vld_a[1])
  );

  sc_s2b_window #(.LOG_LEN(4), .WARMUP(0), .BIPOLAR(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .in(in_bit), .in_vld(in_vld),
    .busy(busy_a[2]), .dout(dout_a[2]), .dout_vld(vld_a[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start accepted on the next edge (edge 0 of the conversion).
  task automatic kick(input int d);
    start_a[d] = 1'b1;
    in_vld     = 1'b1;
    in_bit     = 1'b0;
    tick();
    start_a[d] = 1'b0;
  endtask

  task automatic feed(input logic b);
    in_bit = b;
    in_vld = 1'b1;
    tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) start_a[d] = 1'b0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_busy%0d", d), 32'(busy_a[d]), 32'd0);
      chk($sformatf("reset_vld%0d", d), 32'(vld_a[d]), 32'd0);
      chk($sformatf("reset_dout%0d", d), 32'(dout_a[d]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Unipolar, all ones: result after edge 18
    kick(0);
    chk("uni_busy_after_start", 32'(busy_a[0]), 32'd1);
    for (int i = 0; i < 17; i++) feed(1'b1);
    chk("uni_vld_before_edge18", 32'(vld_a[0]), 32'd0);
    chk("uni_busy_before_edge18", 32'(busy_a[0]), 32'd1);
    feed(1'b1);
    chk("uni_vld_edge18", 32'(vld_a[0]), 32'd1);
    chk("uni_dout_all_ones", 32'(dout_a[0]), 32'd16);
    chk("uni_busy_done", 32'(busy_a[0]), 32'd0);
    in_vld = 1'b0;
    tick();
    chk("uni_vld_one_cycle", 32'(vld_a[0]), 32'd0);
    chk("uni_dout_held", 32'(dout_a[0]), 32'd16);

    // Bipolar, counted bits alternating 1,0 -> 0
    kick(1);
    feed(1'b0);
    feed(1'b0);
    for (int i = 0; i < 16; i++) feed((i % 2) == 0);
    chk("bip_alt_vld", 32'(vld_a[1]), 32'd1);
    chk("bip_alt_dout", 32'(dout_a[1]), 32'd0);
    tick();
    chk("bip_alt_vld_drop", 32'(vld_a[1]), 32'd0);

    // Bipolar, warm bits 1,1 then all zeros -> -16
    kick(1);
    feed(1'b1);
    feed(1'b1);
    for (int i = 0; i < 16; i++) feed(1'b0);
    chk("bip_zero_vld", 32'(vld_a[1]), 32'd1);
    chk("bip_zero_dout", 32'(dout_a[1]), 32'h30);

    // Unipolar, warm bits 1,1 then zeros -> 0 (warm bits not counted)
    kick(0);
    feed(1'b1);
    feed(1'b1);
    for (int i = 0; i < 16; i++) feed(1'b0);
    chk("uni_warm_ignored_vld", 32'(vld_a[0]), 32'd1);
    chk("uni_warm_ignored_dout", 32'(dout_a[0]), 32'd0);

    // No warm-up, in_vld toggling 1,0 with in held 1: accepted edges 2..32
    kick(2);
    for (int i = 1; i <= 31; i++) begin
      in_bit = 1'b1;
      in_vld = ((i % 2) == 0);
      tick();
    end
    chk("w0_vld_before_edge32", 32'(vld_a[2]), 32'd0);
    chk("w0_busy_before_edge32", 32'(busy_a[2]), 32'd1);
    in_bit = 1'b1;
    in_vld = 1'b1;
    tick();
    chk("w0_vld_edge32", 32'(vld_a[2]), 32'd1);
    chk("w0_dout", 32'(dout_a[2]), 32'd16);

    // start mid-ACC ignored: 8 ones then 8 zeros -> 8
    kick(0);
    feed(1'b0);
    feed(1'b0);
    for (int i = 0; i < 16; i++) begin
      start_a[0] = (i == 5);
      feed(i < 8);
    end
    start_a[0] = 1'b0;
    chk("midacc_vld", 32'(vld_a[0]), 32'd1);
    chk("midacc_dout", 32'(dout_a[0]), 32'd8);

    // Back-to-back: start in the dout_vld cycle; 4 ones then zeros -> 4, 18 edges later
    kick(0);
    chk("b2b_busy", 32'(busy_a[0]), 32'd1);
    chk("b2b_vld_drop", 32'(vld_a[0]), 32'd0);
    feed(1'b1);
    feed(1'b1);
    for (int i = 0; i < 15; i++) feed(i < 4);
    chk("b2b_vld_early", 32'(vld_a[0]), 32'd0);
    chk("b2b_dout_prev_held", 32'(dout_a[0]), 32'd8);
    feed(1'b0);
    chk("b2b_vld", 32'(vld_a[0]), 32'd1);
    chk("b2b_dout", 32'(dout_a[0]), 32'd4);

    // Async reset after 7 counted bits
    kick(1);
    feed(1'b0);
    feed(1'b0);
    for (int i = 0; i < 7; i++) feed(1'b1);
    chk("rst_pre_busy", 32'(busy_a[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_a[1]), 32'd0);
    chk("rst_dout", 32'(dout_a[1]), 32'd0);
    chk("rst_vld", 32'(vld_a[1]), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_pulse", 32'(vld_a[1]), 32'd0);

    // Fresh bipolar conversion: 12 ones, 4 zeros -> 2*12-16 = 8
    kick(1);
    feed(1'b1);
    feed(1'b1);
    for (int i = 0; i < 16; i++) feed(i < 12);
    chk("fresh_vld", 32'(vld_a[1]), 32'd1);
    chk("fresh_dout", 32'(dout_a[1]), 32'd8);

    in_vld = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
